// File: rtl/vp_recovery_pkg.sv
// vp_recovery_pkg: shared types and constants for the value-prediction
// recovery controller.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package vp_recovery_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        FLUSH,
        REDIRECT,
        DONE
    } vp_rec_state_t;

    localparam int PC_STEP = 4;
    localparam int AW      = `ADDR_WIDTH;

    // Bits needed to hold 0..max, never narrower than one bit.
    function automatic int cnt_w(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/vp_sat_counter.sv
// vp_sat_counter: clearable up-counter that stops at MAX.
// Used for speculation depth, watchdog, flush length and statistics.
module vp_sat_counter #(
    parameter int WIDTH = 8,
    parameter int MAX   = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             at_max
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    assign at_max = (count == MAX_V);

    // Clear wins over increment; increment stops at MAX.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/vp_recovery_ctrl.sv
// vp_recovery_ctrl: speculation tracking, flush and fetch redirect after a
// value mispredict. Statistics counters exist only with VP_RECOVERY_STATS_EN.
module vp_recovery_ctrl
    import vp_recovery_pkg::*;
#(
    parameter int MAX_SPEC     = 8,
    parameter int FLUSH_CYCLES = 2,
    parameter int TIMEOUT      = 64,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   vp_start,
    input  logic [`ADDR_WIDTH-1:0] vp_pc,
    input  logic                   vp_done,
    input  logic                   vp_recover,
    input  logic                   spec_issue,
    input  logic                   redirect_ready,
    output logic                   recover_en,
    output logic                   recovery_done,
    output logic                   flush,
    output logic                   redirect_valid,
    output logic [`ADDR_WIDTH-1:0] redirect_pc,
    output logic                   spec_stall,
    output logic                   busy,
    output logic [CNT_WIDTH-1:0]   mispredict_cnt,
    output logic [CNT_WIDTH-1:0]   correct_cnt,
    output logic [CNT_WIDTH-1:0]   timeout_cnt
);

    localparam int SW = cnt_w(MAX_SPEC);
    localparam int WW = cnt_w(TIMEOUT - 1);
    localparam int FW = cnt_w(FLUSH_CYCLES - 1);

    vp_rec_state_t          state;
    vp_rec_state_t          nxt;
    logic [`ADDR_WIDTH-1:0] saved_pc;

    logic [SW-1:0] spec_cnt;
    logic [WW-1:0] wdog_cnt;
    logic [FW-1:0] fl_cnt;
    logic          spec_at_max;
    logic          wdog_at_max;
    logic          fl_at_max;
    logic          spec_full;
    logic          wdog_hit;
    logic          fl_hit;
    logic          armed;
    logic          in_flush;

    assign armed    = (state == ARMED);
    assign in_flush = (state == FLUSH);

    vp_sat_counter #(
        .WIDTH(SW),
        .MAX  (MAX_SPEC)
    ) u_spec (
        .clk   (clk),
        .rst   (rst),
        .clr   (!armed),
        .inc   (armed && spec_issue && !spec_at_max),
        .count (spec_cnt),
        .at_max(spec_at_max)
    );

    vp_sat_counter #(
        .WIDTH(WW),
        .MAX  (TIMEOUT - 1)
    ) u_wdog (
        .clk   (clk),
        .rst   (rst),
        .clr   (!armed),
        .inc   (armed && !wdog_at_max),
        .count (wdog_cnt),
        .at_max(wdog_at_max)
    );

    vp_sat_counter #(
        .WIDTH(FW),
        .MAX  (FLUSH_CYCLES - 1)
    ) u_flush (
        .clk   (clk),
        .rst   (rst),
        .clr   (!in_flush),
        .inc   (in_flush && !fl_at_max),
        .count (fl_cnt),
        .at_max(fl_at_max)
    );

    assign spec_full = (spec_cnt == SW'(MAX_SPEC));
    assign wdog_hit  = (wdog_cnt == WW'(TIMEOUT - 1));
    assign fl_hit    = (fl_cnt == FW'(FLUSH_CYCLES - 1));

    assign spec_stall = (armed && spec_full)
                      || in_flush
                      || (state == REDIRECT);

    // Next state: mispredict beats timeout beats correct completion.
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
                if (vp_start) nxt = ARMED;
            end
            ARMED: begin
                if (vp_recover)    nxt = FLUSH;
                else if (wdog_hit) nxt = FLUSH;
                else if (vp_done)  nxt = IDLE;
            end
            FLUSH: begin
                if (fl_hit) nxt = REDIRECT;
            end
            REDIRECT: begin
                if (redirect_ready) nxt = DONE;
            end
            DONE: begin
                nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // State register with outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            recover_en     <= 1'b0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            recovery_done  <= 1'b0;
            busy           <= 1'b0;
            saved_pc       <= '0;
            redirect_pc    <= '0;
        end else begin
            state          <= nxt;
            recover_en     <= (nxt == ARMED);
            flush          <= (nxt == FLUSH);
            redirect_valid <= (nxt == REDIRECT);
            recovery_done  <= (nxt == DONE);
            busy           <= (nxt != IDLE);
            if (state == IDLE && vp_start) begin
                saved_pc <= vp_pc;
            end
            if (in_flush && nxt == REDIRECT) begin
                redirect_pc <= saved_pc + `ADDR_WIDTH'(PC_STEP);
            end
        end
    end

`ifdef VP_RECOVERY_STATS_EN
    logic mis_ev;
    logic to_ev;
    logic ok_ev;
    logic mis_full;
    logic to_full;
    logic ok_full;

    assign mis_ev = armed && vp_recover;
    assign to_ev  = armed && !vp_recover && wdog_hit;
    assign ok_ev  = armed && !vp_recover && !wdog_hit && vp_done;

    vp_sat_counter #(
        .WIDTH(CNT_WIDTH),
        .MAX  ((2 ** CNT_WIDTH) - 1)
    ) u_mis_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (mis_ev && !mis_full),
        .count (mispredict_cnt),
        .at_max(mis_full)
    );

    vp_sat_counter #(
        .WIDTH(CNT_WIDTH),
        .MAX  ((2 ** CNT_WIDTH) - 1)
    ) u_to_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (to_ev && !to_full),
        .count (timeout_cnt),
        .at_max(to_full)
    );

    vp_sat_counter #(
        .WIDTH(CNT_WIDTH),
        .MAX  ((2 ** CNT_WIDTH) - 1)
    ) u_ok_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (ok_ev && !ok_full),
        .count (correct_cnt),
        .at_max(ok_full)
    );
`else
    assign mispredict_cnt = '0;
    assign timeout_cnt    = '0;
    assign correct_cnt    = '0;
`endif

endmodule
